// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 types, error codes and command constants.
package ps2_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_WAIT_CLK,
        S_SHIFT,
        S_ACK,
        S_WAIT_REL
    } ps2_tx_state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_START_TO = 2'd1;
    localparam logic [1:0] ERR_PKT_TO   = 2'd2;
    localparam logic [1:0] ERR_NOACK    = 2'd3;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RESP_ACK     = 8'hFA;
    localparam logic [7:0] RESP_RESEND  = 8'hFE;

    // {stop, odd parity, data}; shifted out LSB first
    function automatic logic [9:0] ps2_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-flop synchroniser plus falling-edge detect for one PS/2 line.
// Flops reset high (idle bus level) so reset release never fakes a falling edge.
module ps2_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic sync,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {meta, sync, prev} <= 3'b111;
        else        {meta, sync, prev} <= {din, meta, sync};
    end

    assign fall = prev & ~sync;

endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device byte transmitter driving open-drain enables.
// Optional PS2_TX_RETRY_EN: resend the latched frame up to MAX_RETRIES times before reporting an error.
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 12000,
    parameter int START_TIMEOUT  = 1500000,
    parameter int PACKET_TIMEOUT = 200000,
    parameter int MAX_RETRIES    = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       tx_done,
    output logic       tx_err,
    output logic [1:0] err_code,
    output logic       busy,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe
);

    localparam int MAXP = (INHIBIT_CYCLES > START_TIMEOUT)
                        ? ((INHIBIT_CYCLES > PACKET_TIMEOUT) ? INHIBIT_CYCLES : PACKET_TIMEOUT)
                        : ((START_TIMEOUT > PACKET_TIMEOUT) ? START_TIMEOUT : PACKET_TIMEOUT);
    localparam int CW = $clog2(MAXP + 1);

    if (INHIBIT_CYCLES < 1 || MAX_RETRIES < 0) begin : g_bad_param
        $error("ps2_host_tx: INHIBIT_CYCLES must be >= 1 and MAX_RETRIES >= 0");
    end

    ps2_tx_state_e state, state_n;
    logic [9:0]    frame, frame_n;
    logic [3:0]    idx, idx_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          clk_oe_n, data_oe_n, done_n, err_n;
    logic [1:0]    code_n, fail;
    logic          clk_sync, clk_fall, data_sync, data_fall_unused;

`ifdef PS2_TX_RETRY_EN
    localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
    logic [RW-1:0] retry, retry_n;
`endif

    ps2_sync_edge u_clk_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_clk_in),
        .sync  (clk_sync),
        .fall  (clk_fall)
    );

    ps2_sync_edge u_data_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (ps2_data_in),
        .sync  (data_sync),
        .fall  (data_fall_unused)
    );

    assign tx_ready = (state == S_IDLE);
    assign busy     = ~tx_ready;

    always_comb begin
        state_n   = state;
        frame_n   = frame;
        idx_n     = idx;
        cnt_n     = (&cnt) ? cnt : cnt + 1'b1;
        clk_oe_n  = ps2_clk_oe;
        data_oe_n = ps2_data_oe;
        done_n    = 1'b0;
        err_n     = 1'b0;
        code_n    = err_code;
        fail      = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
        retry_n   = retry;
`endif
        case (state)
            S_IDLE: begin
                clk_oe_n  = 1'b0;
                data_oe_n = 1'b0;
                if (tx_valid) begin
                    frame_n  = ps2_frame(tx_data);
                    cnt_n    = '0;
                    clk_oe_n = 1'b1;
                    code_n   = ERR_NONE;
                    state_n  = S_INHIBIT;
`ifdef PS2_TX_RETRY_EN
                    retry_n  = '0;
`endif
                end
            end
            S_INHIBIT: begin
                if (cnt == CW'(INHIBIT_CYCLES - 1)) begin
                    data_oe_n = 1'b1;
                    cnt_n     = '0;
                    state_n   = S_REQ;
                end
            end
            S_REQ: begin
                clk_oe_n = 1'b0;
                cnt_n    = '0;
                state_n  = S_WAIT_CLK;
            end
            S_WAIT_CLK: begin
                // a fall in the timeout cycle still counts as the device answering
                if (clk_fall) begin
                    data_oe_n = ~frame[0];
                    idx_n     = 4'd1;
                    cnt_n     = '0;
                    state_n   = S_SHIFT;
                end else if (cnt == CW'(START_TIMEOUT)) begin
                    fail = ERR_START_TO;
                end
            end
            S_SHIFT: begin
                if (clk_fall) begin
                    data_oe_n = ~frame[idx];
                    idx_n     = idx + 4'd1;
                    state_n   = (idx == 4'd9) ? S_ACK : S_SHIFT;
                end else if (cnt == CW'(PACKET_TIMEOUT)) begin
                    fail = ERR_PKT_TO;
                end
            end
            S_ACK: begin
                if (clk_fall) begin
                    if (data_sync) fail = ERR_NOACK;
                    else           state_n = S_WAIT_REL;
                end else if (cnt == CW'(PACKET_TIMEOUT)) begin
                    fail = ERR_PKT_TO;
                end
            end
            S_WAIT_REL: begin
                if (clk_sync && data_sync) begin
                    done_n  = 1'b1;
                    state_n = S_IDLE;
                end else if (cnt == CW'(PACKET_TIMEOUT)) begin
                    fail = ERR_PKT_TO;
                end
            end
            default: state_n = S_IDLE;
        endcase
        if (fail != ERR_NONE) begin
            clk_oe_n  = 1'b0;
            data_oe_n = 1'b0;
            err_n     = 1'b1;
            code_n    = fail;
            state_n   = S_IDLE;
`ifdef PS2_TX_RETRY_EN
            if (retry < RW'(MAX_RETRIES)) begin
                retry_n  = retry + 1'b1;
                clk_oe_n = 1'b1;
                cnt_n    = '0;
                err_n    = 1'b0;
                code_n   = err_code;
                state_n  = S_INHIBIT;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            frame       <= '0;
            idx         <= '0;
            cnt         <= '0;
            ps2_clk_oe  <= 1'b0;
            ps2_data_oe <= 1'b0;
            tx_done     <= 1'b0;
            tx_err      <= 1'b0;
            err_code    <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry       <= '0;
`endif
        end else begin
            state       <= state_n;
            frame       <= frame_n;
            idx         <= idx_n;
            cnt         <= cnt_n;
            ps2_clk_oe  <= clk_oe_n;
            ps2_data_oe <= data_oe_n;
            tx_done     <= done_n;
            tx_err      <= err_n;
            err_code    <= code_n;
`ifdef PS2_TX_RETRY_EN
            retry       <= retry_n;
`endif
        end
    end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: randomized transfers against a behavioural PS/2 keyboard model.
// Timing parameters are shrunk so every scenario fits a short simulation.
module tb_ps2_host_tx;
    import ps2_pkg::*;

    localparam int INH = 40;
    localparam int ST  = 300;
    localparam int PT  = 600;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready, tx_done, tx_err, busy, ps2_clk_oe, ps2_data_oe;
    logic [1:0] err_code;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk, ps2_data;

    assign ps2_clk  = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_data = ~(ps2_data_oe | dev_data_low);

    ps2_host_tx #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .PACKET_TIMEOUT (PT),
        .MAX_RETRIES    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .tx_ready    (tx_ready),
        .tx_done     (tx_done),
        .tx_err      (tx_err),
        .err_code    (err_code),
        .busy        (busy),
        .ps2_clk_in  (ps2_clk),
        .ps2_data_in (ps2_data),
        .ps2_clk_oe  (ps2_clk_oe),
        .ps2_data_oe (ps2_data_oe)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // passive monitors; the main flow takes snapshots and compares differences
    int   cyc = 0, inh = 0, dones = 0, errs = 0, accepts = 0, inh_phases = 0, t_rel = 0, t_err = 0;
    logic [1:0] code_at_err = 2'd0;
    logic oe_at_err = 1'b0;
    logic prev_clk_oe = 1'b0;

    always @(negedge clk) begin
        cyc++;
        if (ps2_clk_oe && !ps2_data_oe) inh++;
        if (ps2_clk_oe && !prev_clk_oe) inh_phases++;
        if (!ps2_clk_oe && prev_clk_oe) t_rel = cyc;
        prev_clk_oe = ps2_clk_oe;
        if (tx_done) dones++;
        if (tx_err) begin
            errs++;
            t_err = cyc;
            code_at_err = err_code;
            oe_at_err = ps2_clk_oe | ps2_data_oe;
        end
        if (tx_valid && tx_ready && rst_n) accepts++;
    end

    function automatic logic [9:0] expect_frame(input logic [7:0] d);
        logic [9:0] f;
        f[7:0] = d;
        f[8]   = ($countones(d) % 2 == 0);
        f[9]   = 1'b1;
        return f;
    endfunction

    // keyboard model: mode 0 = ACK, 1 = never clocks, 2 = data high at ACK clock
    task automatic device(input int mode, input int half, input int nbits,
                          output logic [9:0] bits, output int t_fall1, output bit seen);
        int w = 0;
        bits = '0;
        t_fall1 = 0;
        while (!(ps2_clk && !ps2_data) && w < 4 * INH + 200) begin
            @(negedge clk);
            w++;
        end
        seen = (ps2_clk && !ps2_data);
        if (!seen || mode == 1) return;
        repeat ($urandom_range(5, 40)) @(negedge clk);
        for (int b = 0; b < nbits; b++) begin
            dev_clk_low = 1'b1;
            if (b == 0) t_fall1 = cyc;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[b] = ps2_data;
            repeat (half) @(negedge clk);
        end
        if (nbits == 10) begin
            dev_data_low = (mode == 0);
            repeat (2) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (half) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (2) @(negedge clk);
            dev_data_low = 1'b0;
        end
    endtask

    task automatic xfer(input logic [7:0] d, input int mode, input int nbits, input int half,
                        input bit hold, output logic [9:0] bits, output int t_fall1,
                        output bit seen, output bit ended);
        @(posedge clk);
        #1 tx_data = d;
        tx_valid = 1'b1;
        if (!hold) begin
            @(posedge clk);
            #1 tx_valid = 1'b0;
        end
        fork
            begin
                device(mode, half, nbits, bits, t_fall1, seen);
                if (hold) begin
                    @(posedge clk);
                    #1 tx_valid = 1'b0;
                end
            end
            begin
                int n = 0;
                while (!(tx_done || tx_err) && n < 5000) begin
                    @(negedge clk);
                    n++;
                end
                ended = (tx_done || tx_err);
            end
        join
        repeat (3) @(negedge clk);
    endtask

    logic [9:0] bits;
    int   t_fall1, half, b_inh, b_done, b_err, b_acc, b_ph;
    bit   seen, ended;
    logic [7:0] d;

    task automatic snap();
        b_inh = inh;
        b_done = dones;
        b_err = errs;
        b_acc = accepts;
        b_ph = inh_phases;
    endtask

    task automatic good_xfer(input logic [7:0] byt, input bit hold);
        snap();
        half = $urandom_range(8, 15);
        xfer(byt, 0, 10, half, hold, bits, t_fall1, seen, ended);
        check("req_seen", 32'(seen), 1);
        check("ended", 32'(ended), 1);
        check("frame_bits", 32'(bits), 32'(expect_frame(byt)));
        check("inhibit_len", 32'(inh - b_inh), INH);
        check("done_pulses", 32'(dones - b_done), 1);
        check("err_pulses", 32'(errs - b_err), 0);
        check("err_code_ok", 32'(err_code), 0);
        check("ready_after", 32'(tx_ready), 1);
        if (hold) check("accepts_hold", 32'(accepts - b_acc), 1);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(tx_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_clk_oe", 32'(ps2_clk_oe), 0);
        check("rst_data_oe", 32'(ps2_data_oe), 0);
        check("rst_done", 32'(tx_done), 0);
        check("rst_err", 32'(tx_err), 0);
        check("rst_code", 32'(err_code), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (3) @(negedge clk);

        good_xfer(CMD_SET_LEDS, 1'b0);
        good_xfer(8'h07, 1'b0);
        for (int i = 0; i < 6; i++) good_xfer(8'($urandom), 1'b0);

`ifndef PS2_TX_RETRY_EN
        snap();
        xfer(CMD_RESET, 1, 10, 10, 1'b0, bits, t_fall1, seen, ended);
        check("sto_ended", 32'(ended), 1);
        check("sto_err", 32'(errs - b_err), 1);
        check("sto_code", 32'(code_at_err), 1);
        check("sto_oe", 32'(oe_at_err), 0);
        check("sto_latency", 32'((t_err - t_rel >= ST) && (t_err - t_rel <= ST + 3)), 1);

        snap();
        xfer(8'($urandom), 2, 10, $urandom_range(8, 15), 1'b0, bits, t_fall1, seen, ended);
        check("nack_err", 32'(errs - b_err), 1);
        check("nack_done", 32'(dones - b_done), 0);
        check("nack_code", 32'(code_at_err), 3);
        check("nack_oe", 32'(oe_at_err), 0);

        snap();
        xfer(8'($urandom), 0, 4, 10, 1'b0, bits, t_fall1, seen, ended);
        check("pto_ended", 32'(ended), 1);
        check("pto_err", 32'(errs - b_err), 1);
        check("pto_code", 32'(code_at_err), 2);
        check("pto_latency", 32'((t_err - t_fall1 >= PT) && (t_err - t_fall1 <= PT + 6)), 1);
        check("pto_ready", 32'(tx_ready), 1);
`else
        snap();
        @(posedge clk);
        #1 tx_data = 8'($urandom);
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        device(2, 10, 10, bits, t_fall1, seen);
        device(0, 10, 10, bits, t_fall1, seen);
        repeat (10) @(negedge clk);
        check("retry_phases", 32'(inh_phases - b_ph), 2);
        check("retry_done", 32'(dones - b_done), 1);
        check("retry_err", 32'(errs - b_err), 0);
        check("retry_bits", 32'(bits), 32'(expect_frame(tx_data)));
`endif

        good_xfer(8'($urandom), 1'b1);

        // reset in the middle of the shift phase, off the clock edge
        @(posedge clk);
        #1 tx_data = 8'h00;
        tx_valid = 1'b1;
        @(posedge clk);
        #1 tx_valid = 1'b0;
        for (int w = 0; w < 4 * INH + 200 && !(ps2_clk && !ps2_data); w++) @(negedge clk);
        check("mid_req_seen", 32'(ps2_clk && !ps2_data), 1);
        repeat (10) @(negedge clk);
        for (int b = 0; b < 3; b++) begin
            dev_clk_low = 1'b1;
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
        end
        check("mid_busy", 32'(busy), 1);
        check("mid_data_oe", 32'(ps2_data_oe), 1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_clk_oe", 32'(ps2_clk_oe), 0);
        check("arst_data_oe", 32'(ps2_data_oe), 0);
        check("arst_ready", 32'(tx_ready), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rel_ready", 32'(tx_ready), 1);
        repeat (5) @(negedge clk);

        good_xfer(8'($urandom), 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter: sends one command byte (e.g. 0xED set-LEDs, 0xFF reset) from the game logic to the keyboard over the same PS2Clk/PS2Data lines the receiver listens on.
- Performs the request-to-send sequence, shifts the frame on device-generated clock edges, checks the device ACK and reports done or error.
- Runs on the 100 MHz system clock.
- Drives open-drain enables only; the top level ties each line low when its enable is 1, and releases it (high-Z, pulled up) otherwise.

Parameters:
- INHIBIT_CYCLES, 12000: cycles PS2Clk is held low before the request (120 us at 100 MHz).
- START_TIMEOUT, 1500000: max cycles from clock release to the first device falling edge (15 ms).
- PACKET_TIMEOUT, 200000: max cycles from the first falling edge to ACK sampled (2 ms).
- MAX_RETRIES, 2: retry count; used only with PS2_TX_RETRY_EN.

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  asynchronous active-low reset
- tx_data  in  8  byte to send
- tx_valid  in  1  request; accepted when tx_valid && tx_ready
- tx_ready  out  1  high only in IDLE
- tx_done  out  1  one-cycle pulse: byte sent and ACKed
- tx_err  out  1  one-cycle pulse: transfer failed
- err_code  out  2  valid with tx_err, held until the next accept. 1 = start timeout, 2 = packet timeout, 3 = no ACK.
- busy  out  1  ~tx_ready; the receiver discards frames while this is high
- ps2_clk_in  in  1  raw PS2Clk
- ps2_data_in  in  1  raw PS2Data
- ps2_clk_oe  out  1  1 = pull PS2Clk low
- ps2_data_oe  out  1  1 = pull PS2Data low

Behaviour:
- Reset (async, any state): state=IDLE, both oe=0, tx_ready=1, tx_done=0, tx_err=0, err_code=0, busy=0, counters cleared.
- Lines are released immediately on reset, including mid-transfer.
- Input conditioning:
  - ps2_clk_in and ps2_data_in each go through a 2-flop synchroniser.
  - fall = prev_sync & ~sync on the clock line. This adds 2–3 cycles of latency, which is negligible against the 10–16.7 kHz PS/2 clock.
- Frame register: 10 bits = {stop=1, parity=~^tx_data, tx_data[7:0]}, sent LSB first.
- States:
  - IDLE: oe both 0.
    - On accept: latch the frame, clear the counter, set clk_oe=1, go to INHIBIT.
    - tx_valid while not ready is ignored; no queueing.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles, then REQ.
  - REQ: one cycle with clk_oe=1 and data_oe=1 (start bit 0), then WAIT_CLK.
  - WAIT_CLK: clk_oe=0, data_oe=1, timer counting.
    - On the first fall: data_oe <= ~frame[0], idx=1, go to SHIFT.
    - On timer == START_TIMEOUT: error code 1.
  - SHIFT: on each fall, data_oe <= ~frame[idx] and idx++.
    - When idx==10 is reached (stop bit placed, data_oe=0), go to ACK.
  - ACK: on the next fall, sample data_sync.
    - 0 → WAIT_REL.
    - 1 → error code 3.
  - WAIT_REL: wait until clk_sync=1 and data_sync=1, then pulse tx_done and return to IDLE in the same transition.
  - Packet timer: starts at the first fall and runs through SHIFT, ACK and WAIT_REL. Reaching PACKET_TIMEOUT gives error code 2.
- Error path (any code): both oe=0 the same cycle, pulse tx_err, set err_code, go to IDLE. tx_ready is high the following cycle.
- Timeout and fall in the same cycle: the fall wins.
- Counters are sized with $clog2 of the largest parameter and saturate; no wrap.

Optional Feature:
PS2_TX_RETRY_EN
- Defined: on any error, the latched frame is resent from INHIBIT, up to MAX_RETRIES additional attempts.
  - tx_err and err_code (last failure) are reported only after the final attempt fails.
  - busy stays high throughout.
  - The retry counter resets on accept.
- Undefined: the first error is reported immediately; no retry logic is synthesised.

Decomposition:
- ps2_pkg: state enum; err_code constants (ERR_NONE, ERR_START_TO, ERR_PKT_TO, ERR_NOACK); command constants (CMD_SET_LEDS=8'hED, CMD_RESET=8'hFF, RESP_ACK=8'hFA, RESP_RESEND=8'hFE).
- Sub-module ps2_sync_edge: 2-flop synchroniser plus falling-edge detect. Instantiated twice here and shared with the receiver.

Test Plan:
- Send 0xED with a device model clocking at 12.5 kHz and ACKing → clk_oe held 12000 cycles; data bits 1,0,1,1,0,1,1,1; parity 1; stop 1; tx_done pulse; err_code=0.
- Send 0x07 → bits 1,1,1,0,0,0,0,0; parity 0 → tx_done.
- Device never clocks → tx_err after 1500000 cycles in WAIT_CLK; err_code=1; both oe=0.
- Device holds data high at the ACK clock → tx_err; err_code=3.
- Device stops clocking after 4 bits → tx_err at the 200000-cycle packet timeout; err_code=2.
- rst_n low mid-SHIFT → oe both 0 asynchronously; tx_ready=1 after release.
- tx_valid held high while busy → exactly one transfer.
- With PS2_TX_RETRY_EN: first attempt NACKed, second ACKed → two INHIBIT phases, one tx_done, no tx_err.
